counter_input_conditioner: RTL

//   Front end for the 5-bit ring/Johnson shift counter. Synchronises and debounces the raw

---
 rtl/counter_input_conditioner_pkg.sv | 10 +
 rtl/counter_input_conditioner_debounce_sync.sv | 35 +++
 rtl/counter_input_conditioner.sv | 82 ++++++++
 3 files changed

// File: rtl/counter_input_conditioner_pkg.sv
// cond_pkg: load FSM encoding and default timing constants for the counter input conditioner
package cond_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_TICK_DIV        = 25000000;
endpackage

// File: rtl/counter_input_conditioner_debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a group debounce shared by all bits
module debounce_sync #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);
    localparam int CW = $clog2(CYCLES + 1);
    logic [WIDTH-1:0] r_s1, r_s2, r_stable;
    logic [CW-1:0]    r_cnt;
    // accept the synced value once it has differed from the stable value for CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
    assign o_stable = r_stable;
endmodule

// File: rtl/counter_input_conditioner.sv
// counter_input_conditioner: debounced switches, single-cycle load pulse with captured number, step tick
module counter_input_conditioner
    import cond_pkg::*;
#(
    parameter int NUM_W           = 5,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sw_mode_raw,
    input  logic             i_sw_control_raw,
    input  logic [NUM_W-1:0] i_sw_nums_raw,
    output logic             o_sw_mode,
    output logic             o_load_pulse,
    output logic [NUM_W-1:0] o_nums_out,
    output logic             o_step_tick
);
    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    logic             w_mode, w_ctrl, w_mode_chg, w_load, w_tick;
    logic [NUM_W-1:0] w_nums;
    logic             r_mode_prev;
    logic [NUM_W-1:0] r_nums;
    logic [PW-1:0]    r_pre;
    state_t           r_state, w_next;

    debounce_sync #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst(rst), .i_raw(i_sw_mode_raw), .o_stable(w_mode)
    );
    debounce_sync #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_ctrl (
        .clk(clk), .rst(rst), .i_raw(i_sw_control_raw), .o_stable(w_ctrl)
    );
    debounce_sync #(.WIDTH(NUM_W), .CYCLES(DEBOUNCE_CYCLES)) u_nums (
        .clk(clk), .rst(rst), .i_raw(i_sw_nums_raw), .o_stable(w_nums)
    );

    assign w_mode_chg = w_mode != r_mode_prev;

    // load FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state, load strobe, and tick gating (ticks only pass while idle)
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_tick = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next = w_ctrl ? LOAD : IDLE;
                w_tick = r_pre == PRE_MAX;
            end
            LOAD: begin
                w_next = HOLD;
                w_load = 1'b1;
            end
            HOLD:    w_next = w_ctrl ? HOLD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // number capture on entry to LOAD, prescaler restarted by a load or a fresh mode level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_prev <= 1'b0;
            r_nums      <= '0;
            r_pre       <= '0;
        end else begin
            r_mode_prev <= w_mode;
            if (r_state == IDLE && w_ctrl) r_nums <= w_nums;
            r_pre <= (r_state == LOAD || w_mode_chg || r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
        end
    end

    assign o_sw_mode    = w_mode;
    assign o_load_pulse = w_load;
    assign o_nums_out   = r_nums;
    assign o_step_tick  = w_tick;
endmodule
